// File: rtl/fir_filter_dual_tdm.sv
// Dual-channel symmetric FIR with one shared pre-adder and multiplier,
// time-multiplexed over IR then RED for every accepted sample pair.
module fir_filter_dual_tdm #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 22,
  parameter int COEF_W = 9,
  parameter int OUT_W  = 20,
  localparam int HALF  = TAPS / 2,
  localparam int AW    = $clog2(HALF)
) (
  input  logic                     CLK_Filter,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        IR_ADC_Value,
  input  logic [DATA_W-1:0]        RED_ADC_Value,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     flush,
  output logic [OUT_W-1:0]         Out_IR_Filtered,
  output logic [OUT_W-1:0]         Out_RED_Filtered,
  output logic                     out_valid,
  output logic                     sat_ir,
  output logic                     sat_red
);

  localparam int ACC_W = DATA_W + 1 + COEF_W + AW;
  localparam int DW    = $clog2(TAPS);
  localparam int CW    = (ACC_W > OUT_W ? ACC_W : OUT_W) + 1;

  typedef enum logic [1:0] {
    IDLE,
    MAC_IR,
    MAC_RED,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [AW-1:0]            idx;
  logic [DATA_W-1:0]        ir_dl  [TAPS];
  logic [DATA_W-1:0]        red_dl [TAPS];
  logic signed [COEF_W-1:0] coef   [HALF];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  ir_hold;

  logic                     take;
  logic                     wr;
  logic                     last;
  logic [DW-1:0]            lo;
  logic [DW-1:0]            hi;
  logic [DATA_W-1:0]        x_lo;
  logic [DATA_W-1:0]        x_hi;
  logic [DATA_W:0]          pre;
  logic signed [ACC_W-1:0]  pre_x;
  logic signed [ACC_W-1:0]  coef_x;
  logic signed [ACC_W-1:0]  prod;

  assign in_ready = (state == IDLE);
  assign take     = in_ready & in_valid & ~flush;
  assign wr       = in_ready & coef_we & (int'(coef_addr) < HALF);
  assign last     = (idx == AW'(HALF - 1));

  // Symmetric pair: tap idx and its mirror share one coefficient
  assign lo     = DW'(idx);
  assign hi     = DW'(TAPS - 1) - lo;
  assign x_lo   = (state == MAC_RED) ? red_dl[lo] : ir_dl[lo];
  assign x_hi   = (state == MAC_RED) ? red_dl[hi] : ir_dl[hi];
  assign pre    = {1'b0, x_lo} + {1'b0, x_hi};
  assign pre_x  = $signed({{(ACC_W-DATA_W-1){1'b0}}, pre});
  assign coef_x = {{(ACC_W-COEF_W){coef[idx][COEF_W-1]}}, coef[idx]};
  assign prod   = pre_x * coef_x;

  function automatic logic [OUT_W:0] clamp(
    input logic signed [ACC_W-1:0] a
  );
    logic [CW-1:0] ext;
    logic [CW-1:0] lim;
    ext = {{(CW-ACC_W){a[ACC_W-1]}}, a};
    lim = {{(CW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    if (a[ACC_W-1])
      return {1'b1, {OUT_W{1'b0}}};
    else if (ext > lim)
      return {1'b1, {OUT_W{1'b1}}};
    else
      return {1'b0, ext[OUT_W-1:0]};
  endfunction

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take) state_nxt = MAC_IR;
      MAC_IR:  if (last) state_nxt = MAC_RED;
      MAC_RED: if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flush has priority over a transfer in the same cycle
  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        ir_dl[i]  <= '0;
        red_dl[i] <= '0;
      end
      for (int i = 0; i < HALF; i++)
        coef[i] <= '0;
    end else begin
      if (wr)
        coef[coef_addr] <= coef_data;
      if (in_ready && flush) begin
        for (int i = 0; i < TAPS; i++) begin
          ir_dl[i]  <= '0;
          red_dl[i] <= '0;
        end
      end else if (take) begin
        ir_dl[0]  <= IR_ADC_Value;
        red_dl[0] <= RED_ADC_Value;
        for (int i = 1; i < TAPS; i++) begin
          ir_dl[i]  <= ir_dl[i-1];
          red_dl[i] <= red_dl[i-1];
        end
      end
    end
  end

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      idx              <= '0;
      acc              <= '0;
      ir_hold          <= '0;
      Out_IR_Filtered  <= '0;
      Out_RED_Filtered <= '0;
      sat_ir           <= 1'b0;
      sat_red          <= 1'b0;
      out_valid        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            idx <= '0;
            acc <= '0;
          end
        end
        MAC_IR: begin
          idx <= last ? '0 : idx + 1'b1;
          if (last) begin
            ir_hold <= acc + prod;
            acc     <= '0;
          end else begin
            acc <= acc + prod;
          end
        end
        MAC_RED: begin
          idx <= last ? '0 : idx + 1'b1;
          acc <= acc + prod;
        end
        DONE: begin
          {sat_ir, Out_IR_Filtered}   <= clamp(ir_hold);
          {sat_red, Out_RED_Filtered} <= clamp(acc);
          out_valid                   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter_dual_tdm.sv
// Bench for fir_filter_dual_tdm: scoreboard against a direct-form
// reference, two instances (20-bit and 16-bit outputs) on shared stimulus.
module tb_fir_filter_dual_tdm;

  localparam int DATA_W = 8;
  localparam int TAPS   = 22;
  localparam int COEF_W = 9;
  localparam int HALF   = TAPS / 2;
  localparam int AW     = $clog2(HALF);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              coef_we = 1'b0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] ir_in = '0;
  logic [DATA_W-1:0] red_in = '0;
  logic [AW-1:0]     coef_addr = '0;
  logic [COEF_W-1:0] coef_data = '0;

  logic        in_ready, out_valid, sat_ir, sat_red;
  logic [19:0] out_ir, out_red;
  logic        in_ready16, out_valid16, sat_ir16, sat_red16;
  logic [15:0] out_ir16, out_red16;

  always #5 clk = ~clk;

  fir_filter_dual_tdm dut (
    .CLK_Filter(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .IR_ADC_Value(ir_in), .RED_ADC_Value(red_in),
    .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .flush(flush),
    .Out_IR_Filtered(out_ir), .Out_RED_Filtered(out_red),
    .out_valid(out_valid), .sat_ir(sat_ir), .sat_red(sat_red)
  );

  fir_filter_dual_tdm #(.OUT_W(16)) dut16 (
    .CLK_Filter(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready16),
    .IR_ADC_Value(ir_in), .RED_ADC_Value(red_in),
    .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .flush(flush),
    .Out_IR_Filtered(out_ir16), .Out_RED_Filtered(out_red16),
    .out_valid(out_valid16), .sat_ir(sat_ir16), .sat_red(sat_red16)
  );

  typedef struct {
    longint ir;
    longint red;
    bit     sir;
    bit     sred;
    longint cyc;
  } exp_t;

  exp_t   q20[$];
  exp_t   q16[$];
  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  int     mc[HALF];
  int     hir[TAPS];
  int     hred[TAPS];
  int     base[HALF] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128};

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: event did not occur as expected", nm);
  endtask

  function automatic longint fir(input int h[TAPS]);
    longint s = 0;
    for (int i = 0; i < HALF; i++)
      s += longint'(mc[i]) * longint'(h[i] + h[TAPS-1-i]);
    return s;
  endfunction

  function automatic void clampv(input longint a, input int w,
                                 output longint v, output bit s);
    longint mx = (longint'(1) << w) - 1;
    if (a < 0) begin
      v = 0; s = 1;
    end else if (a > mx) begin
      v = mx; s = 1;
    end else begin
      v = a; s = 0;
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < HALF; i++) mc[i] = 0;
    for (int i = 0; i < TAPS; i++) begin
      hir[i] = 0; hred[i] = 0;
    end
    q20.delete();
    q16.delete();
  endtask

  task automatic xfer(input int ir, input int red);
    longint ai, ar;
    exp_t e;
    for (int i = TAPS - 1; i > 0; i--) begin
      hir[i] = hir[i-1]; hred[i] = hred[i-1];
    end
    hir[0] = ir; hred[0] = red;
    ai = fir(hir);
    ar = fir(hred);
    e.cyc = cyc + TAPS + 2;
    clampv(ai, 20, e.ir, e.sir);
    clampv(ar, 20, e.red, e.sred);
    q20.push_back(e);
    clampv(ai, 16, e.ir, e.sir);
    clampv(ar, 16, e.red, e.sred);
    q16.push_back(e);
  endtask

  // Predict the effect of the coming edge, then advance to just after it
  task automatic tick();
    @(negedge clk);
    if (rst_n && in_ready) begin
      if (coef_we && int'(coef_addr) < HALF)
        mc[coef_addr] = int'($signed(coef_data));
      if (flush) begin
        for (int i = 0; i < TAPS; i++) begin
          hir[i] = 0; hred[i] = 0;
        end
      end else if (in_valid) begin
        xfer(int'(ir_in), int'(red_in));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input int ir, input int red);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick(); n++;
    end
    if (!in_ready) fail_now("send_timeout");
    in_valid = 1'b1;
    ir_in    = DATA_W'(ir);
    red_in   = DATA_W'(red);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic write_coef(input int addr, input logic [COEF_W-1:0] d);
    coef_we   = 1'b1;
    coef_addr = AW'(addr);
    coef_data = d;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic load_base();
    for (int i = 0; i < HALF; i++)
      write_coef(i, COEF_W'(base[i]));
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Returns at the negedge of the out_valid cycle
  task automatic wait_out(input string nm);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk); n++;
    end
    if (!out_valid) fail_now(nm);
  endtask

  task automatic realign();
    @(posedge clk); #1;
  endtask

  function automatic logic [COEF_W-1:0] rc();
    int v;
    v = int'($urandom_range(0, 295)) - 40;
    return COEF_W'(v);
  endfunction

  function automatic int imp(input int n);
    return (n < HALF) ? base[n] : base[TAPS-1-n];
  endfunction

  longint l_ir = 0, l_red = 0;
  bit     l_si = 0, l_sr = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      l_ir = 0; l_red = 0; l_si = 0; l_sr = 0;
    end else if (out_valid) begin
      if (q20.size() == 0) begin
        fail_now("unexpected_out_valid");
      end else begin
        e = q20.pop_front();
        check("ir20", longint'(out_ir), e.ir);
        check("red20", longint'(out_red), e.red);
        check("sat_ir20", longint'(sat_ir), longint'(e.sir));
        check("sat_red20", longint'(sat_red), longint'(e.sred));
        check("latency", cyc, e.cyc);
      end
      l_ir = out_ir; l_red = out_red; l_si = sat_ir; l_sr = sat_red;
    end else begin
      check("hold", {sat_ir, sat_red, out_ir, out_red},
            {l_si, l_sr, l_ir[19:0], l_red[19:0]});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid16) begin
      if (q16.size() == 0) begin
        fail_now("unexpected_out_valid16");
      end else begin
        e = q16.pop_front();
        check("ir16", longint'(out_ir16), e.ir);
        check("red16", longint'(out_red16), e.red);
        check("sat_ir16", longint'(sat_ir16), longint'(e.sir));
        check("sat_red16", longint'(sat_red16), longint'(e.sred));
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_outs", longint'({out_ir, out_red, sat_ir, sat_red}), 0);
    rst_n = 1'b1;
    realign();

    // Impulse response, including ignored out-of-range writes
    load_base();
    for (int a = HALF; a < 16; a++) write_coef(a, 9'h1ff);
    for (int n = 0; n < TAPS; n++) begin
      send(n == 0 ? 1 : 0, 0);
      wait_out("imp_timeout");
      check("imp_ir", longint'(out_ir), imp(n));
      check("imp_red", longint'(out_red), 0);
      realign();
    end

    // Full-scale DC: 20-bit fits, 16-bit clamps
    for (int n = 0; n < TAPS; n++) send(255, 100);
    wait_out("dc_timeout");
    check("dc_ir", longint'(out_ir), 353430);
    check("dc_red", longint'(out_red), 138600);
    check("dc_sat", longint'({sat_ir, sat_red}), 0);
    check("dc16_ir", longint'(out_ir16), 65535);
    check("dc16_red", longint'(out_red16), 65535);
    check("dc16_sat", longint'({sat_ir16, sat_red16}), 3);
    realign();

    // Negative coefficients clamp to zero
    for (int i = 0; i < HALF; i++) write_coef(i, 9'h1ff);
    do_flush();
    send(10, 0);
    wait_out("neg_timeout");
    check("neg_ir", longint'(out_ir), 0);
    check("neg_sat_ir", longint'(sat_ir), 1);
    realign();

    // Coefficient write while busy is ignored
    load_base();
    send(5, 5);
    tick();
    write_coef(0, 9'd99);
    wait_out("busy_timeout");
    realign();
    do_flush();
    send(1, 0);
    wait_out("busy_rb_timeout");
    check("busy_coef_rb", longint'(out_ir), 2);
    realign();

    // Reset during the RED pass aborts the sample
    send(7, 9);
    repeat (HALF + 3) tick();
    rst_n = 1'b0;
    model_reset();
    #2;
    check("mid_rst_outs", longint'({out_ir, out_red}), 0);
    check("mid_rst_valid", longint'(out_valid), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    realign();
    check("post_rst_ready", longint'(in_ready), 1);
    repeat (TAPS + 4) tick();

    // Flush beats a simultaneous sample
    load_base();
    for (int n = 0; n < TAPS; n++)
      send(int'($urandom_range(1, 255)), int'($urandom_range(1, 255)));
    wait_out("fl_pre_timeout");
    realign();
    check("flush_ready", longint'(in_ready), 1);
    flush = 1'b1; in_valid = 1'b1; ir_in = 8'd200; red_in = 8'd200;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int n = 0; n < TAPS; n++) begin
      send(n == 0 ? 1 : 0, 0);
      wait_out("fl_imp_timeout");
      check("fl_imp_ir", longint'(out_ir), imp(n));
      check("fl_imp_red", longint'(out_red), 0);
      realign();
    end

    // Randomized traffic
    for (int i = 0; i < HALF; i++) write_coef(i, rc());
    for (int t = 0; t < 80; t++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        write_coef(int'($urandom_range(0, 15)), rc());
      end else if (r == 1) begin
        flush = 1'b1;
        in_valid = 1'($urandom_range(0, 1));
        ir_in = DATA_W'($urandom_range(0, 255));
        tick();
        flush = 1'b0; in_valid = 1'b0;
      end else begin
        send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        if ($urandom_range(0, 2) == 0)
          write_coef(int'($urandom_range(0, HALF - 1)), rc());
        if ($urandom_range(0, 3) == 0)
          repeat ($urandom_range(1, 30)) tick();
      end
    end

    repeat (TAPS + 6) tick();
    check("drain", longint'(q20.size() + q16.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir_filter_dual_tdm.md
FIR_FILTER_DUAL_TDM -- requirements
Module: fir_filter_dual_tdm

Interface
REQ-001 Parameter DATA_W, default 8: unsigned ADC sample width.
REQ-002 Parameter TAPS, default 22: filter length; even, >=4; coefficients symmetric, TAPS/2 stored.
REQ-003 Parameter COEF_W, default 9: signed two's-complement coefficient width.
REQ-004 Parameter OUT_W, default 20: unsigned output width.
REQ-005 CLK_Filter  in  1  single clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  sample pair present on IR_ADC_Value/RED_ADC_Value.
REQ-008 in_ready  out  1  block accepts a sample pair this cycle.
REQ-009 IR_ADC_Value  in  DATA_W  IR channel sample.
REQ-010 RED_ADC_Value  in  DATA_W  RED channel sample.
REQ-011 coef_we  in  1  coefficient write strobe.
REQ-012 coef_addr  in  clog2(TAPS/2)  coefficient index 0..TAPS/2-1.
REQ-013 coef_data  in  COEF_W  signed coefficient value.
REQ-014 flush  in  1  clear both delay lines.
REQ-015 Out_IR_Filtered, Out_RED_Filtered  out  OUT_W each  filtered results.
REQ-016 out_valid  out  1  one-cycle pulse, both outputs updated.
REQ-017 sat_ir, sat_red  out  1 each  saturation occurred on the result presented with out_valid.

Function
REQ-018 Transfer per channel: y = sum_{i=0..TAPS/2-1} c[i]*(x[n-i] + x[n-(TAPS-1-i)]), x[n] newest accepted sample.
REQ-019 Single shared pre-adder (DATA_W+1 bits) and single signed multiplier, time-multiplexed over both channels.
REQ-020 FSM states: IDLE, MAC_IR, MAC_RED, DONE.
REQ-021 in_ready = 1 only in IDLE; transfer occurs when in_valid & in_ready.
REQ-022 On transfer: both delay lines shift by one, new samples enter position 0, FSM -> MAC_IR, pair index cleared, accumulator cleared.
REQ-023 MAC_IR: exactly TAPS/2 cycles, one coefficient pair per cycle, index 0 upward; then -> MAC_RED.
REQ-024 MAC_RED: exactly TAPS/2 cycles, same order; then -> DONE.
REQ-025 DONE: both outputs and sat flags registered, out_valid = 1 for that one cycle, -> IDLE.
REQ-026 Latency: transfer at edge k -> out_valid high in the cycle following edge k+TAPS+1; maximum throughput one pair per TAPS+2 cycles.
REQ-027 Accumulator signed, width DATA_W+1+COEF_W+clog2(TAPS/2); no internal overflow possible.
REQ-028 Output clamp: acc<0 -> 0 with sat=1; acc>2^OUT_W-1 -> 2^OUT_W-1 with sat=1; else acc[OUT_W-1:0] with sat=0.
REQ-029 Outputs and sat flags hold their values between out_valid pulses.
REQ-030 Coefficient write takes effect at the edge when coef_we=1 in IDLE; writes outside IDLE or with coef_addr>=TAPS/2 are ignored.
REQ-031 flush in IDLE zeros all delay-line entries at that edge; flush outside IDLE is ignored.
REQ-032 flush and in_valid both high in IDLE: flush wins, no transfer, in_ready still reads 1, sample dropped.
REQ-033 coef_we and transfer in the same IDLE cycle: write occurs first; the computation started uses the new coefficient.
REQ-034 Delay lines never change outside a transfer or flush.

Reset
REQ-035 rst_n low: FSM -> IDLE, delay lines, accumulator, index = 0, outputs = 0, out_valid = 0, sat flags = 0, coefficients = 0, effective immediately regardless of clock.
REQ-036 Reset mid-computation aborts it; no out_valid is produced for the aborted sample; in_ready = 1 from the first edge after rst_n release.

Verification
REQ-037 Load c = {2,10,16,28,43,60,78,95,111,122,128}; IR impulse 1 then 21 zeros, RED zero -> 22 consecutive IR outputs 2,10,16,28,43,60,78,95,111,122,128,128,122,...,10,2; RED outputs all 0.
REQ-038 Same coefficients, 22 samples IR=255, RED=100 -> 22nd result IR 353430, RED 138600, sat flags 0.
REQ-039 OUT_W=16, same stimulus -> IR 65535 with sat_ir=1, RED 65535 with sat_red=1 (138600>65535).
REQ-040 All coefficients -1, IR=10 -> IR output 0, sat_ir=1.
REQ-041 Assert rst_n low during MAC_RED -> no out_valid, outputs 0, in_ready=1 after release; coef_we while busy leaves coefficient unchanged (readback by impulse).
REQ-042 After 22 nonzero samples, flush with simultaneous in_valid, then one impulse -> sample ignored; response equals fresh-impulse response of REQ-037.
